// File: rtl/run_pattern_tx.sv
// Serial LSB-first pattern transmitter with start/busy/done handshake and a cycle-exact
// model of the four-in-a-row detector output. Define RUN_PATTERN_TX_REPEAT_EN to chain frames.
module run_pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             w_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             z_exp_o
);

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StSend = 3'b010,
        StDone = 3'b100
    } state_e;

    localparam logic [LEN_W-1:0] WidthLen = LEN_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rc_q, rc_d;
    logic             lb_q;
    logic [LEN_W-1:0] len_clamp;
    logic             load_req;

    assign len_clamp = (len_i > WidthLen) ? WidthLen : len_i;
    assign load_req  = start_i && (len_i != '0);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        w_o     = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    sr_d    = data_i;
                    cnt_d   = len_clamp;
                    state_d = StSend;
                end
            end
            StSend: begin
                w_o     = sr_q[0];
                valid_o = 1'b1;
                busy_o  = 1'b1;
                sr_d    = sr_q >> 1;
                cnt_d   = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
`ifdef RUN_PATTERN_TX_REPEAT_EN
                    // Chain the next frame straight after the last bit.
                    if (load_req) begin
                        sr_d  = data_i;
                        cnt_d = len_clamp;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end
            end
            StDone: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Run-length tracker mirroring the detector's sampling of w, idle cycles included.
    always_comb begin
        rc_d = rc_q;
        if (rc_q == 3'd0 || w_o != lb_q) begin
            rc_d = 3'd1;
        end else if (rc_q != 3'd4) begin
            rc_d = rc_q + 3'd1;
        end
    end

    assign z_exp_o = (rc_q == 3'd4);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            rc_q    <= '0;
            lb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            lb_q    <= w_o;
        end
    end

endmodule

// File: tb/tb_run_pattern_tx.sv
// Self-checking bench for run_pattern_tx: directed and random frames against a
// queue-based transaction model; honours RUN_PATTERN_TX_REPEAT_EN when defined.
module tb_run_pattern_tx;

`ifdef RUN_PATTERN_TX_REPEAT_EN
    localparam bit Repeat = 1'b1;
`else
    localparam bit Repeat = 1'b0;
`endif

    typedef struct packed {
        logic w;
        logic valid;
        logic busy;
        logic done;
        logic last;
    } ent_t;

    localparam ent_t Idle = '0;

    logic       clk  = 1'b0;
    logic       aclr = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = '0;
    logic [3:0] len   = '0;
    logic       w, valid, busy, done, z_exp;

    int   vectors     = 0;
    int   miscompares = 0;
    ent_t q[$];
    ent_t cur = Idle;
    bit   hist[$];

    run_pattern_tx #(
        .WIDTH(8),
        .LEN_W(4)
    ) dut (
        .clk    (clk),
        .aclr   (aclr),
        .start_i(start),
        .data_i (data),
        .len_i  (len),
        .w_o    (w),
        .valid_o(valid),
        .busy_o (busy),
        .done_o (done),
        .z_exp_o(z_exp)
    );

    always #5 clk = ~clk;

    // z is high when the last four sampled w values since reset are all equal.
    function automatic logic [4:0] exp_vec();
        logic z;
        z = (hist.size() == 4) && (hist[0] == hist[1]) && (hist[1] == hist[2])
            && (hist[2] == hist[3]);
        return {cur.w, cur.valid, cur.busy, cur.done, z};
    endfunction

    task automatic model_reset();
        q.delete();
        hist.delete();
        cur = Idle;
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [3:0] l);
        int   n;
        ent_t e;
        n = (l > 4'd8) ? 8 : int'(l);
        for (int i = 0; i < n; i++) begin
            e = '{w: d[i], valid: 1'b1, busy: 1'b1, done: 1'b0, last: (i == n - 1)};
            q.push_back(e);
        end
    endtask

    // Drive inputs for the coming rising edge and advance the model across it.
    task automatic apply(input logic s, input logic [7:0] d, input logic [3:0] l);
        start = s;
        data  = d;
        len   = l;
        if (aclr) begin
            hist.push_back(cur.w);
            if (hist.size() > 4) hist.pop_front();
            if (cur.last) begin
                if (Repeat && s && l != 4'd0) push_frame(d, l);
                else q.push_back('{w: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1, last: 1'b0});
            end else if (!cur.busy && s && l != 4'd0) begin
                push_frame(d, l);
            end
            cur = (q.size() > 0) ? q.pop_front() : Idle;
        end
    endtask

    task automatic test_reset();
        #1 aclr = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d got %b want 00000", i,
                         {w, valid, busy, done, z_exp});
            end
        end
        aclr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 8'h00, 4'd0);
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d got %b want %b", i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic [3:0] l);
        for (int i = 0; i < 14; i++) begin
            apply(i == 0, d, l);
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s cyc %0d got %b want %b", name, i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
    endtask

    task automatic test_len_limits();
        int ones = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 4) apply(1'b1, 8'hFF, 4'd0);
            else apply(i == 4, 8'hFF, 4'd12);
            @(negedge clk);
            if (valid === 1'b1 && w === 1'b1) ones++;
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL len_limits cyc %0d got %b want %b", i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
        vectors++;
        if (ones !== 8) begin
            miscompares++;
            $display("FAIL len_clamp_ones got %0d want 8", ones);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            apply(i == 0, 8'h5B, 4'd8);
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL mid_reset_pre cyc %0d got %b want %b", i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
        #1 aclr = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({w, valid, busy, done, z_exp} !== 5'b00000) begin
            miscompares++;
            $display("FAIL mid_reset_async got %b want 00000", {w, valid, busy, done, z_exp});
        end
        for (int i = 0; i < 13; i++) begin
            if (i == 3) aclr = 1'b1;
            apply(1'b0, 8'hFF, 4'd8);
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL mid_reset_post cyc %0d got %b want %b", i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            apply(1'b1, 8'h0F, 4'd4);
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d got %b want %b", i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 8'h00, 4'd0);
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_drain cyc %0d got %b want %b", i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic       s;
        logic [7:0] d;
        logic [3:0] l;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 2) == 0);
            d = 8'($urandom);
            l = 4'($urandom_range(0, 15));
            apply(s, d, l);
            @(negedge clk);
            vectors++;
            if ({w, valid, busy, done, z_exp} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d got %b want %b", i,
                         {w, valid, busy, done, z_exp}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame("frame_f0", 8'hF0, 4'd8);
        test_frame("frame_aa", 8'hAA, 4'd5);
        test_len_limits();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
